sha1_ctrl: RTL and testbench



---
 rtl/sha1_ctrl_if.sv | 38 +++
 rtl/sha1_ctrl.sv | 99 +++++++++
 tb/tb_sha1_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sha1_ctrl_if.sv
// sha1_ctrl_if: host/datapath handshake bundle for the SHA-1 controller (SHA1_CTRL_PERF_CNT_EN adds perf counters)
interface sha1_ctrl_if;
  logic        process_i;
  logic        init_i;
  logic        digestack_i;
  logic        ready_o;
  logic        init_o;
  logic        load_o;
  logic        round_en_o;
  logic [6:0]  round_o;
  logic [31:0] kconst_o;
  logic [1:0]  func_sel_o;
  logic        w_expand_o;
  logic        update_o;
  logic        digestvalid_o;
  logic        busy_o;
  logic        error_o;
`ifdef SHA1_CTRL_PERF_CNT_EN
  logic [31:0] blocks_o;
  logic [31:0] cycles_o;
`endif
  modport slave (
    input  process_i, init_i, digestack_i,
    output ready_o, init_o, load_o, round_en_o, round_o, kconst_o, func_sel_o,
           w_expand_o, update_o, digestvalid_o, busy_o, error_o
`ifdef SHA1_CTRL_PERF_CNT_EN
    , output blocks_o, cycles_o
`endif
  );
  modport master (
    output process_i, init_i, digestack_i,
    input  ready_o, init_o, load_o, round_en_o, round_o, kconst_o, func_sel_o,
           w_expand_o, update_o, digestvalid_o, busy_o, error_o
`ifdef SHA1_CTRL_PERF_CNT_EN
    , input blocks_o, cycles_o
`endif
  );
endinterface

// File: rtl/sha1_ctrl.sv
// sha1_ctrl: SHA-1 compression sequencer (LOAD/ROUND/UPDATE/DONE); SHA1_CTRL_PERF_CNT_EN adds block/cycle counters
module sha1_ctrl #(
  parameter int RoundsPerCycle = 1,
  localparam int NumCycles = 80 / RoundsPerCycle
) (
  input logic       clk_i,
  input logic       rst_i,
  sha1_ctrl_if.slave bus
);
  if (!(RoundsPerCycle == 1 || RoundsPerCycle == 2 || RoundsPerCycle == 4)) begin : g_bad_rpc
    $error("sha1_ctrl: RoundsPerCycle must be 1, 2 or 4");
  end
  localparam logic [6:0] Step = 7'(RoundsPerCycle);
  localparam logic [6:0] Last = 7'(RoundsPerCycle * (NumCycles - 1));
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, UPDATE, DONE} state_e;
  state_e     state_q, state_d;
  logic [6:0] round_q, round_d;
  logic       init_q, init_d;
  logic       error_q, error_d;
  logic       busy, accept, last;
  // next state: a start is accepted only when idle or holding a digest
  always_comb begin
    busy = state_q == LOAD || state_q == ROUND || state_q == UPDATE;
    accept = bus.process_i && (state_q == IDLE || state_q == DONE);
    last = round_q == Last;
    state_d = state_q;
    round_d = round_q;
    init_d = accept ? bus.init_i : init_q;
    error_d = bus.process_i && busy;
    case (state_q)
      IDLE:    state_d = accept ? LOAD : IDLE;
      LOAD:    state_d = ROUND;
      ROUND: begin
        state_d = last ? UPDATE : ROUND;
        round_d = last ? 7'd0 : round_q + Step;
      end
      UPDATE:  state_d = DONE;
      DONE:    state_d = accept ? LOAD : bus.digestack_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state, round counter, latched init flag and rejected-start pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      round_q <= '0;
      init_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      init_q  <= init_d;
      error_q <= error_d;
    end
  end
  // strobes and round decode; K and function are zero outside ROUND
  always_comb begin
    bus.ready_o       = state_q == IDLE || state_q == DONE;
    bus.init_o        = state_q == LOAD && init_q;
    bus.load_o        = state_q == LOAD;
    bus.round_en_o    = state_q == ROUND;
    bus.round_o       = bus.round_en_o ? round_q : 7'd0;
    bus.kconst_o      = !bus.round_en_o ? 32'h0 :
                        round_q < 7'd20 ? 32'h5A827999 :
                        round_q < 7'd40 ? 32'h6ED9EBA1 :
                        round_q < 7'd60 ? 32'h8F1BBCDC : 32'hCA62C1D6;
    bus.func_sel_o    = !bus.round_en_o ? 2'd0 :
                        round_q < 7'd20 ? 2'd0 :
                        round_q < 7'd40 ? 2'd1 :
                        round_q < 7'd60 ? 2'd2 : 2'd3;
    bus.w_expand_o    = bus.round_en_o && round_q >= 7'd16;
    bus.update_o      = state_q == UPDATE;
    bus.digestvalid_o = state_q == DONE;
    bus.busy_o        = busy;
    bus.error_o       = error_q;
  end
`ifdef SHA1_CTRL_PERF_CNT_EN
  logic [31:0] blocks_q, blocks_d, cycles_q, cycles_d;
  logic        clr;
  // a new message (accepted start with init) restarts both counters
  always_comb begin
    clr = accept && bus.init_i;
    blocks_d = clr ? 32'd0 : blocks_q + {31'd0, state_q == UPDATE};
    cycles_d = clr ? 32'd0 : cycles_q + {31'd0, busy};
  end
  // performance counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blocks_q <= '0;
      cycles_q <= '0;
    end else begin
      blocks_q <= blocks_d;
      cycles_q <= cycles_d;
    end
  end
  assign bus.blocks_o = blocks_q;
  assign bus.cycles_o = cycles_q;
`endif
endmodule

// File: tb/tb_sha1_ctrl.sv
// tb_sha1_ctrl: scoreboard bench for sha1_ctrl at RoundsPerCycle 1 and 4
module tb_sha1_ctrl;
  typedef struct packed {
    logic        ready;
    logic        init;
    logic        load;
    logic        round_en;
    logic [6:0]  round;
    logic [31:0] k;
    logic [1:0]  fsel;
    logic        wexp;
    logic        update;
    logic        dv;
    logic        busy;
    logic        err;
  } exp_t;
  typedef struct {
    exp_t  v;
    string tag;
  } item_t;
  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    checks = 0;
  int    errors = 0;
  item_t q1[$];
  item_t q4[$];
  exp_t  a1, a4;
  sha1_ctrl_if if1();
  sha1_ctrl_if if4();
  sha1_ctrl #(.RoundsPerCycle(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));
  sha1_ctrl #(.RoundsPerCycle(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(if4));
  always #5 clk = ~clk;
  assign a1 = {if1.ready_o, if1.init_o, if1.load_o, if1.round_en_o, if1.round_o, if1.kconst_o,
               if1.func_sel_o, if1.w_expand_o, if1.update_o, if1.digestvalid_o, if1.busy_o, if1.error_o};
  assign a4 = {if4.ready_o, if4.init_o, if4.load_o, if4.round_en_o, if4.round_o, if4.kconst_o,
               if4.func_sel_o, if4.w_expand_o, if4.update_o, if4.digestvalid_o, if4.busy_o, if4.error_o};
  // st: 0 idle, 1 load, 2 round, 3 update, 4 done
  function automatic exp_t ex(input int st, input int r = 0, input logic ini = 1'b0, input logic err = 1'b0);
    exp_t e = '0;
    case (st)
      0: e.ready = 1'b1;
      1: begin e.load = 1'b1; e.init = ini; e.busy = 1'b1; end
      2: begin
        e.round_en = 1'b1;
        e.round = 7'(r);
        e.k = r < 20 ? 32'h5A827999 : r < 40 ? 32'h6ED9EBA1 : r < 60 ? 32'h8F1BBCDC : 32'hCA62C1D6;
        e.fsel = r < 20 ? 2'd0 : r < 40 ? 2'd1 : r < 60 ? 2'd2 : 2'd3;
        e.wexp = r >= 16;
        e.busy = 1'b1;
      end
      3: begin e.update = 1'b1; e.busy = 1'b1; end
      default: begin e.ready = 1'b1; e.dv = 1'b1; end
    endcase
    e.err = err;
    return e;
  endfunction
  task automatic chk(input string tag, input logic [49:0] act, input logic [49:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, want);
    end
  endtask
  // one cycle of stimulus on DUT d (0: R=1, 1: R=4) plus the outputs expected during it
  task automatic step(input bit d, input logic p, input logic i, input logic a, input logic r,
                      input exp_t e, input string tag);
    @(negedge clk);
    rst = r;
    if (d) begin
      if4.process_i = p; if4.init_i = i; if4.digestack_i = a;
      q4.push_back('{e, tag});
    end else begin
      if1.process_i = p; if1.init_i = i; if1.digestack_i = a;
      q1.push_back('{e, tag});
    end
  endtask
  task automatic rounds(input bit d, input int st, input int from, input int to);
    for (int r = from; r <= to; r += st) step(d, 0, 0, 0, 0, ex(2, r), $sformatf("round%0d", r));
  endtask
  // monitor: compare whatever each DUT presents against the queued expectation
  always @(negedge clk) begin
    item_t it;
    #1;
    if (q1.size() > 0) begin it = q1.pop_front(); chk({"r1_", it.tag}, a1, it.v); end
    if (q4.size() > 0) begin it = q4.pop_front(); chk({"r4_", it.tag}, a4, it.v); end
  end
  initial begin
    if1.process_i = 0; if1.init_i = 0; if1.digestack_i = 0;
    if4.process_i = 0; if4.init_i = 0; if4.digestack_i = 0;
    step(0, 0, 0, 0, 1, ex(0), "reset");
    step(0, 1, 1, 0, 0, ex(0), "idle_start");
    step(0, 0, 0, 0, 0, ex(1, 0, 1), "load_init");
    rounds(0, 1, 0, 79);
    step(0, 0, 0, 0, 0, ex(3), "update");
    step(0, 0, 0, 0, 0, ex(4), "done");
    step(0, 0, 0, 0, 0, ex(4), "done_hold");
    step(0, 0, 0, 1, 0, ex(4), "done_ack");
    step(0, 0, 0, 1, 0, ex(0), "ack_in_idle");
    step(0, 0, 0, 0, 0, ex(0), "idle_no_err");
    step(0, 1, 0, 0, 0, ex(0), "start2");
    step(0, 0, 0, 0, 0, ex(1), "load_chain");
    rounds(0, 1, 0, 39);
    step(0, 1, 1, 0, 0, ex(2, 40), "round40_proc");
    step(0, 0, 0, 0, 0, ex(2, 41, 0, 1), "round41_err");
    rounds(0, 1, 42, 79);
    step(0, 0, 0, 0, 0, ex(3), "update2");
    step(0, 0, 0, 0, 0, ex(4), "done2");
    step(0, 1, 0, 1, 0, ex(4), "done_proc_ack");
    step(0, 0, 0, 0, 0, ex(1), "load_implicit_ack");
    rounds(0, 1, 0, 49);
    step(0, 0, 0, 0, 1, ex(0), "abort_rst");
    step(0, 0, 0, 0, 0, ex(0), "after_rst");
    step(0, 0, 0, 0, 0, ex(0), "no_update");
    step(0, 1, 1, 0, 0, ex(0), "start3");
    step(0, 0, 0, 0, 0, ex(1, 0, 1), "load3");
    rounds(0, 1, 0, 79);
    step(0, 0, 0, 0, 0, ex(3), "update3");
    step(0, 0, 0, 1, 0, ex(4), "done3_ack");
    step(0, 0, 0, 0, 0, ex(0), "idle3");
    step(1, 0, 0, 0, 0, ex(0), "idle");
    step(1, 1, 1, 0, 0, ex(0), "start");
    step(1, 0, 0, 0, 0, ex(1, 0, 1), "load_init");
    rounds(1, 4, 0, 76);
    step(1, 0, 0, 0, 0, ex(3), "update");
    step(1, 0, 0, 0, 0, ex(4), "done");
    step(1, 1, 0, 0, 0, ex(4), "done_proc");
    step(1, 0, 0, 0, 0, ex(1), "load_chain");
    rounds(1, 4, 0, 76);
    step(1, 0, 0, 0, 0, ex(3), "update2");
    step(1, 0, 0, 0, 0, ex(4), "done2");
`ifdef SHA1_CTRL_PERF_CNT_EN
    #2;
    chk("r4_blocks", 50'(if4.blocks_o), 50'd2);
    chk("r4_cycles", 50'(if4.cycles_o), 50'd44);
`endif
    @(negedge clk);
    #3;
    if (q1.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d/%0d want 0/0", q1.size(), q4.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
